// File: rtl/arb_2m1s_pkg.sv
// Shared types for the two-master MemSplit32 arbiter: master ID and default read depth.
package arb_2m1s_pkg;
  typedef logic mid_t;
  localparam int unsigned RD_DEPTH_DEF = 4;
endpackage

// File: rtl/arb_id_fifo.sv
// In-order ID FIFO; head valid the cycle after push; push while full and pop while empty are dropped.
module arb_id_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_dat,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_head,
  output logic [$clog2(DEPTH):0]   o_cnt,
  output logic                     o_full,
  output logic                     o_empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_rd_ptr;
  logic [AW-1:0]    r_wr_ptr;
  logic [AW:0]      r_cnt;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_cnt == (AW+1)'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign o_cnt   = r_cnt;
  assign o_head  = r_mem[r_rd_ptr];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_cnt    <= '0;
      for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_dat;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
        2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end
endmodule

// File: rtl/arb_2m1s.sv
// Round-robin 2:1 MemSplit32 arbiter; zero-latency request/response paths.
// Reads stall (ack=0) while RD_DEPTH reads are outstanding; writes still pass.
module arb_2m1s
  import arb_2m1s_pkg::*;
#(
  parameter int unsigned RD_DEPTH = RD_DEPTH_DEF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        i_m0_req,
  output logic        o_m0_ack,
  input  logic        i_m0_we,
  input  logic [31:0] i_m0_addr,
  input  logic [3:0]  i_m0_be,
  input  logic [31:0] i_m0_wdata,
  output logic        o_m0_resp,
  output logic [31:0] o_m0_rdata,
  input  logic        i_m1_req,
  output logic        o_m1_ack,
  input  logic        i_m1_we,
  input  logic [31:0] i_m1_addr,
  input  logic [3:0]  i_m1_be,
  input  logic [31:0] i_m1_wdata,
  output logic        o_m1_resp,
  output logic [31:0] o_m1_rdata,
  output logic        o_s_req,
  input  logic        i_s_ack,
  output logic        o_s_we,
  output logic [31:0] o_s_addr,
  output logic [3:0]  o_s_be,
  output logic [31:0] o_s_wdata,
  input  logic        i_s_resp,
  input  logic [31:0] i_s_rdata
);
  logic                        r_rr;
  logic                        r_lock_vld;
  mid_t                        r_lock_id;
  logic                        w_elig0;
  logic                        w_elig1;
  logic                        w_gnt_vld;
  mid_t                        w_gnt_id;
  logic                        w_acc;
  logic                        w_push;
  logic                        w_pop;
  mid_t                        w_head;
  logic [$clog2(RD_DEPTH):0]   w_cnt;
  logic                        w_full;
  logic                        w_empty;

  assign w_elig0 = i_m0_req && (i_m0_we || !w_full);
  assign w_elig1 = i_m1_req && (i_m1_we || !w_full);

  // A pending lock wins so the slave never sees the request change mid-handshake.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_id  = 1'b0;
    if (r_lock_vld) begin
      w_gnt_vld = 1'b1;
      w_gnt_id  = r_lock_id;
    end else if (w_elig0 && w_elig1) begin
      w_gnt_vld = 1'b1;
      w_gnt_id  = r_rr;
    end else if (w_elig0) begin
      w_gnt_vld = 1'b1;
      w_gnt_id  = 1'b0;
    end else if (w_elig1) begin
      w_gnt_vld = 1'b1;
      w_gnt_id  = 1'b1;
    end
  end

  always_comb begin
    o_s_req   = 1'b0;
    o_s_we    = 1'b0;
    o_s_addr  = '0;
    o_s_be    = '0;
    o_s_wdata = '0;
    if (w_gnt_vld && (w_gnt_id == 1'b0)) begin
      o_s_req   = i_m0_req;
      o_s_we    = i_m0_we;
      o_s_addr  = i_m0_addr;
      o_s_be    = i_m0_be;
      o_s_wdata = i_m0_wdata;
    end else if (w_gnt_vld) begin
      o_s_req   = i_m1_req;
      o_s_we    = i_m1_we;
      o_s_addr  = i_m1_addr;
      o_s_be    = i_m1_be;
      o_s_wdata = i_m1_wdata;
    end
  end

  assign o_m0_ack = o_s_req && i_s_ack && (w_gnt_id == 1'b0);
  assign o_m1_ack = o_s_req && i_s_ack && (w_gnt_id == 1'b1);
  assign w_acc    = o_s_req && i_s_ack;
  assign w_push   = w_acc && !o_s_we;
  assign w_pop    = i_s_resp && (w_cnt != '0);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_rr       <= 1'b0;
      r_lock_vld <= 1'b0;
      r_lock_id  <= 1'b0;
    end else begin
      if (w_acc) begin
        r_rr       <= ~w_gnt_id;
        r_lock_vld <= 1'b0;
      end else if (o_s_req) begin
        r_lock_vld <= 1'b1;
        r_lock_id  <= w_gnt_id;
      end
    end
  end

  arb_id_fifo #(
    .DEPTH (RD_DEPTH),
    .WIDTH (1)
  ) u_id_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .i_push  (w_push),
    .i_dat   (w_gnt_id),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_cnt   (w_cnt),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // With nothing outstanding a stray slave response is dropped.
  assign o_m0_resp  = i_s_resp && !w_empty && (w_head == 1'b0);
  assign o_m1_resp  = i_s_resp && !w_empty && (w_head == 1'b1);
  assign o_m0_rdata = o_m0_resp ? i_s_rdata : '0;
  assign o_m1_rdata = o_m1_resp ? i_s_rdata : '0;
endmodule

// File: tb/tb_arb_2m1s.sv
// Directed bench for arb_2m1s: contention, lock, full stall, ordering and reset.
module tb_arb_2m1s;
  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        i_m0_req = 1'b0, i_m0_we = 1'b0;
  logic [31:0] i_m0_addr = '0, i_m0_wdata = '0;
  logic [3:0]  i_m0_be = '0;
  logic        i_m1_req = 1'b0, i_m1_we = 1'b0;
  logic [31:0] i_m1_addr = '0, i_m1_wdata = '0;
  logic [3:0]  i_m1_be = '0;
  logic        i_s_ack = 1'b0, i_s_resp = 1'b0;
  logic [31:0] i_s_rdata = '0;
  logic        o_m0_ack, o_m0_resp, o_m1_ack, o_m1_resp;
  logic [31:0] o_m0_rdata, o_m1_rdata;
  logic        o_s_req, o_s_we;
  logic [31:0] o_s_addr, o_s_wdata;
  logic [3:0]  o_s_be;

  int n_tests = 0;
  int n_fail  = 0;

  arb_2m1s #(.RD_DEPTH(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .i_m0_req(i_m0_req), .o_m0_ack(o_m0_ack), .i_m0_we(i_m0_we), .i_m0_addr(i_m0_addr),
    .i_m0_be(i_m0_be), .i_m0_wdata(i_m0_wdata), .o_m0_resp(o_m0_resp), .o_m0_rdata(o_m0_rdata),
    .i_m1_req(i_m1_req), .o_m1_ack(o_m1_ack), .i_m1_we(i_m1_we), .i_m1_addr(i_m1_addr),
    .i_m1_be(i_m1_be), .i_m1_wdata(i_m1_wdata), .o_m1_resp(o_m1_resp), .o_m1_rdata(o_m1_rdata),
    .o_s_req(o_s_req), .i_s_ack(i_s_ack), .o_s_we(o_s_we), .o_s_addr(o_s_addr),
    .o_s_be(o_s_be), .o_s_wdata(o_s_wdata), .i_s_resp(i_s_resp), .i_s_rdata(i_s_rdata)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drv(input int m, input logic req, input logic we, input logic [31:0] addr);
    if (m == 0) begin
      i_m0_req = req; i_m0_we = we; i_m0_addr = addr; i_m0_be = 4'hF; i_m0_wdata = ~addr;
    end else begin
      i_m1_req = req; i_m1_we = we; i_m1_addr = addr; i_m1_be = 4'hF; i_m1_wdata = ~addr;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int ord_m  [4] = '{0, 1, 1, 0};
    int ord_rx [5] = '{0, 0, 1, 1, 0};

    #2;
    chk("rst_s_req", {31'b0, o_s_req}, 32'd0);
    chk("rst_s_addr", o_s_addr, 32'd0);
    chk("rst_m0_ack", {31'b0, o_m0_ack}, 32'd0);
    chk("rst_m1_resp", {31'b0, o_m1_resp}, 32'd0);
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b1;

    // Contention: both masters write every cycle, slave acks every cycle.
    drv(0, 1, 1, 32'h10); drv(1, 1, 1, 32'h20); i_s_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rr_addr", o_s_addr, (i % 2 == 0) ? 32'h10 : 32'h20);
      chk("rr_m0_ack", {31'b0, o_m0_ack}, (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("rr_m1_ack", {31'b0, o_m1_ack}, (i % 2 == 0) ? 32'd0 : 32'd1);
      tick();
    end
    drv(0, 0, 0, 0); drv(1, 0, 0, 0); i_s_ack = 1'b0;

    // Single read from m0, response two cycles later.
    drv(0, 1, 0, 32'h100); i_s_ack = 1'b1;
    #1;
    chk("rd_addr", o_s_addr, 32'h100);
    chk("rd_we", {31'b0, o_s_we}, 32'd0);
    chk("rd_m0_ack", {31'b0, o_m0_ack}, 32'd1);
    tick();
    drv(0, 0, 0, 0); i_s_ack = 1'b0;
    #1 chk("rd_noresp", {31'b0, o_m0_resp}, 32'd0);
    tick();
    i_s_resp = 1'b1; i_s_rdata = 32'hA5A5A5A5;
    #1;
    chk("rd_m0_resp", {31'b0, o_m0_resp}, 32'd1);
    chk("rd_m0_rdata", o_m0_rdata, 32'hA5A5A5A5);
    chk("rd_m1_resp", {31'b0, o_m1_resp}, 32'd0);
    chk("rd_m1_rdata", o_m1_rdata, 32'd0);
    tick();
    i_s_resp = 1'b0;

    // m1 write so rr points back at m0 before the lock test.
    drv(1, 1, 1, 32'h40); i_s_ack = 1'b1;
    tick();
    drv(1, 0, 0, 0); i_s_ack = 1'b0;

    // Lock: m1 granted, ack withheld 3 cycles while m0 also requests.
    drv(1, 1, 1, 32'h200);
    #1 chk("lock_first", o_s_addr, 32'h200);
    tick();
    drv(0, 1, 1, 32'h300);
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("lock_hold_addr", o_s_addr, 32'h200);
      chk("lock_hold_m0_ack", {31'b0, o_m0_ack}, 32'd0);
      tick();
    end
    i_s_ack = 1'b1;
    #1;
    chk("lock_acc_addr", o_s_addr, 32'h200);
    chk("lock_acc_m1_ack", {31'b0, o_m1_ack}, 32'd1);
    chk("lock_acc_m0_ack", {31'b0, o_m0_ack}, 32'd0);
    tick();
    drv(1, 0, 0, 0);
    #1;
    chk("lock_next_addr", o_s_addr, 32'h300);
    chk("lock_next_m0_ack", {31'b0, o_m0_ack}, 32'd1);
    tick();
    drv(0, 0, 0, 0); i_s_ack = 1'b0;

    // Full: four reads outstanding, fifth stalls, a write still passes.
    i_s_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drv(0, 1, 0, 32'h400 + 32'(4 * i));
      tick();
    end
    drv(0, 1, 0, 32'h500); drv(1, 1, 1, 32'h600);
    #1;
    chk("full_wr_addr", o_s_addr, 32'h600);
    chk("full_wr_m1_ack", {31'b0, o_m1_ack}, 32'd1);
    chk("full_rd_m0_ack", {31'b0, o_m0_ack}, 32'd0);
    tick();
    drv(1, 0, 0, 0);
    #1;
    chk("full_s_req", {31'b0, o_s_req}, 32'd0);
    chk("full_m0_ack", {31'b0, o_m0_ack}, 32'd0);
    tick();
    i_s_resp = 1'b1; i_s_rdata = 32'h11;
    #1;
    chk("full_samepop_ack", {31'b0, o_m0_ack}, 32'd0);
    chk("full_pop_resp", {31'b0, o_m0_resp}, 32'd1);
    tick();
    i_s_resp = 1'b0;
    #1;
    chk("full_5th_addr", o_s_addr, 32'h500);
    chk("full_5th_ack", {31'b0, o_m0_ack}, 32'd1);
    tick();
    drv(0, 0, 0, 0); i_s_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      i_s_resp = 1'b1; i_s_rdata = 32'h20 + 32'(i);
      #1 chk("drain_m0_resp", {31'b0, o_m0_resp}, 32'd1);
      tick();
    end
    i_s_resp = 1'b0;

    // Ordering: reads m0,m1,m1,m0 with overlapping in-order responses 1..4, then a stray response.
    i_s_ack = 1'b1;
    for (int c = 0; c < 6; c++) begin
      drv(0, 0, 0, 0); drv(1, 0, 0, 0);
      if (c < 4) drv(ord_m[c], 1, 0, 32'h700 + 32'(c));
      i_s_resp  = (c >= 1);
      i_s_rdata = (c == 5) ? 32'hDEAD : 32'(c);
      #1;
      if (c < 4)
        chk("ord_ack", {31'b0, (ord_m[c] == 0) ? o_m0_ack : o_m1_ack}, 32'd1);
      if (c >= 1 && c <= 4) begin
        chk("ord_m0_resp", {31'b0, o_m0_resp}, (ord_rx[c] == 0) ? 32'd1 : 32'd0);
        chk("ord_m1_resp", {31'b0, o_m1_resp}, (ord_rx[c] == 1) ? 32'd1 : 32'd0);
        chk("ord_rdata", (ord_rx[c] == 0) ? o_m0_rdata : o_m1_rdata, 32'(c));
      end
      if (c == 5) begin
        chk("ord_stray_m0", {31'b0, o_m0_resp}, 32'd0);
        chk("ord_stray_m1", {31'b0, o_m1_resp}, 32'd0);
      end
      tick();
    end
    drv(0, 0, 0, 0); drv(1, 0, 0, 0); i_s_resp = 1'b0; i_s_ack = 1'b0;

    // Reset with two reads outstanding.
    i_s_ack = 1'b1;
    drv(0, 1, 0, 32'h800);
    tick();
    drv(0, 0, 0, 0); drv(1, 1, 0, 32'h804);
    tick();
    drv(1, 0, 0, 0); i_s_ack = 1'b0;
    #1 rst_i = 1'b0;
    #1;
    chk("rstmid_s_req", {31'b0, o_s_req}, 32'd0);
    chk("rstmid_m0_ack", {31'b0, o_m0_ack}, 32'd0);
    i_s_resp = 1'b1; i_s_rdata = 32'h55;
    #1;
    chk("rstmid_m0_resp", {31'b0, o_m0_resp}, 32'd0);
    chk("rstmid_m0_rdata", o_m0_rdata, 32'd0);
    chk("rstmid_m1_resp", {31'b0, o_m1_resp}, 32'd0);
    tick();
    rst_i = 1'b1;
    #1;
    chk("rstrel_m0_resp", {31'b0, o_m0_resp}, 32'd0);
    chk("rstrel_m1_resp", {31'b0, o_m1_resp}, 32'd0);
    tick();
    i_s_resp = 1'b0;
    drv(0, 1, 1, 32'h10); drv(1, 1, 1, 32'h20); i_s_ack = 1'b1;
    #1;
    chk("rstrel_rr_addr", o_s_addr, 32'h10);
    chk("rstrel_rr_m0_ack", {31'b0, o_m0_ack}, 32'd1);
    tick();
    drv(0, 0, 0, 0); drv(1, 0, 0, 0); i_s_ack = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
